// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU definitions: data width, op-code constants and exec-unit FSM states.
// Also used by the ALU control decoder.
package alu_defs;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [3:0] {
      ALU_ADD     = 4'd0,
      ALU_ADD_ALT = 4'd1,
      ALU_SUB     = 4'd2,
      ALU_AND     = 4'd3,
      ALU_OR      = 4'd4,
      ALU_SLT     = 4'd5,
      ALU_SRL     = 4'd6,
      ALU_SLL     = 4'd7,
      ALU_SRA     = 4'd8
   } alu_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } alu_state_e;

   typedef enum logic [1:0] {
      SH_SRL = 2'd0,
      SH_SLL = 2'd1,
      SH_SRA = 2'd2
   } shift_mode_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SRL) || (op == ALU_SLL) || (op == ALU_SRA);
   endfunction

   function automatic shift_mode_e shift_mode(input logic [3:0] op);
      case (op)
         ALU_SLL: return SH_SLL;
         ALU_SRA: return SH_SRA;
         default: return SH_SRL;
      endcase
   endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: loads operand, amount and direction, then moves one bit per
// enabled cycle while counting down.
module alu_serial_shifter
   import alu_defs::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [3:0]        shamt_i,
   input  shift_mode_e       mode_i,
   output logic [DATA_W-1:0] shifted_o,
   output logic              last_o
);

   logic [DATA_W-1:0] data_q, data_d;
   logic [3:0]        count_q, count_d;
   shift_mode_e       mode_q, mode_d;

   always_comb begin
      case (mode_q)
         SH_SLL:  shifted_o = {data_q[DATA_W-2:0], 1'b0};
         SH_SRA:  shifted_o = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
         default: shifted_o = {1'b0, data_q[DATA_W-1:1]};
      endcase
   end

   assign last_o = (count_q == 4'd1);

   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      mode_d  = mode_q;
      if (load_i) begin
         data_d  = data_i;
         count_d = shamt_i;
         mode_d  = mode_i;
      end else if (shift_i) begin
         data_d  = shifted_o;
         count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         count_q <= '0;
         mode_q  <= SH_SRL;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
         mode_q  <= mode_d;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic ops, multi-cycle serial shifts,
// registered result/flags with a one-cycle done pulse.
module alu_exec_unit
   import alu_defs::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        aluControl,
   input  logic [DATA_W-1:0] operandA,
   input  logic [DATA_W-1:0] operandB,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              overflow
);

   alu_state_e        state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] sum, diff, alu_res, shifted;
   logic              alu_ovf, sh_load, sh_step, sh_last, shift_multi;

   assign sum  = operandA + operandB;
   assign diff = operandA - operandB;
   assign shift_multi = is_shift_op(aluControl) && (operandB[3:0] != 4'd0);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (aluControl)
         ALU_ADD, ALU_ADD_ALT: begin
            alu_res = sum;
            alu_ovf = (operandA[DATA_W-1] == operandB[DATA_W-1]) &&
                      (sum[DATA_W-1] != operandA[DATA_W-1]);
         end
         ALU_SUB: begin
            alu_res = diff;
            alu_ovf = (operandA[DATA_W-1] != operandB[DATA_W-1]) &&
                      (diff[DATA_W-1] != operandA[DATA_W-1]);
         end
         ALU_AND: alu_res = operandA & operandB;
         ALU_OR:  alu_res = operandA | operandB;
         ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
         // Zero-length shifts complete immediately with the unshifted operand.
         ALU_SRL, ALU_SLL, ALU_SRA: alu_res = operandA;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      sh_load  = 1'b0;
      sh_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (shift_multi) begin
                  sh_load = 1'b1;
                  state_d = ST_SHIFT;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  ovf_d    = alu_ovf;
                  done_d   = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            sh_step = 1'b1;
            if (sh_last) begin
               state_d  = ST_IDLE;
               result_d = shifted;
               zero_d   = (shifted == '0);
               ovf_d    = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   alu_serial_shifter u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load_i    (sh_load),
      .shift_i   (sh_step),
      .data_i    (operandA),
      .shamt_i   (operandB[3:0]),
      .mode_i    (shift_mode(aluControl)),
      .shifted_o (shifted),
      .last_o    (sh_last)
   );

   assign busy     = (state_q == ST_SHIFT);
   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, random ops against an
// arithmetic reference model, and hand-written multi-cycle corner sequences.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  aluControl = '0;
   logic [15:0] operandA = '0;
   logic [15:0] operandB = '0;
   logic        busy, done, zero, overflow;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .aluControl (aluControl),
      .operandA   (operandA),
      .operandB   (operandB),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .zero       (zero),
      .overflow   (overflow)
   );

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_res;
      logic        exp_zero;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected behaviour from plain signed/unsigned arithmetic.
   function automatic void ref_model(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b, output logic [15:0] r,
                                     output logic o, output int lat);
      int sa, sb, s, n;
      sa = $signed(a);
      sb = $signed(b);
      n = int'(b[3:0]);
      o = 1'b0;
      lat = 1;
      s = 0;
      case (op)
         4'd0, 4'd1: begin s = sa + sb; r = s[15:0]; o = (s > 32767) || (s < -32768); end
         4'd2: begin s = sa - sb; r = s[15:0]; o = (s > 32767) || (s < -32768); end
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = (sa < sb) ? 16'd1 : 16'd0;
         4'd6: begin r = a >> n; lat = n + 1; end
         4'd7: begin r = a << n; lat = n + 1; end
         4'd8: begin r = $signed(a) >>> n; lat = n + 1; end
         default: r = 16'd0;
      endcase
   endfunction

   // Issue one op and wait (bounded) for done; inputs are scrambled while busy.
   task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt, output logic [15:0] r,
                        output logic z, output logic o);
      @(negedge clk);
      start = 1'b1; aluControl = op; operandA = a; operandB = b;
      lat = 0; busy_cnt = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         aluControl = 4'($urandom_range(0, 15));
         operandA = 16'($urandom);
         operandB = 16'($urandom);
         lat++;
         if (busy) busy_cnt++;
      end while (!done && lat < 40);
      r = result; z = zero; o = overflow;
   endtask

   task automatic check_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b);
      logic [15:0] er, r;
      logic eo, z, o;
      int el, lat, bc;
      ref_model(op, a, b, er, eo, el);
      do_op(op, a, b, lat, bc, r, z, o);
      chk({tag, " result"}, 32'(r), 32'(er));
      chk({tag, " zero"}, 32'(z), 32'(er == 16'd0));
      chk({tag, " overflow"}, 32'(o), 32'(eo));
      chk({tag, " latency"}, 32'(lat), 32'(el));
      chk({tag, " busy cycles"}, 32'(bc), 32'(el - 1));
   endtask

   vec_t vecs[$];

   initial begin
      logic [15:0] r_hold;
      int first_done, n_done, lat, bc;
      logic [15:0] r;
      logic z, o;

      vecs.push_back('{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1});
      vecs.push_back('{4'd1, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1});
      vecs.push_back('{4'd2, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1});
      vecs.push_back('{4'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1});
      vecs.push_back('{4'd3, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1});
      vecs.push_back('{4'd4, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1});
      vecs.push_back('{4'd5, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1});
      vecs.push_back('{4'd5, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1});
      vecs.push_back('{4'd8, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 5});
      vecs.push_back('{4'd6, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 5});
      vecs.push_back('{4'd7, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1});
      vecs.push_back('{4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1});
      vecs.push_back('{4'd7, 16'h0003, 16'h000F, 16'h8000, 1'b0, 1'b0, 16});

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", 32'(result), 32'd0);
      chk("reset zero", 32'(zero), 32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc, r, z, o);
         chk($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].exp_res));
         chk($sformatf("vec%0d zero", i), 32'(z), 32'(vecs[i].exp_zero));
         chk($sformatf("vec%0d overflow", i), 32'(o), 32'(vecs[i].exp_ovf));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(vecs[i].exp_lat - 1));
      end

      // Result/flags hold and done stays a single pulse while idle.
      r_hold = result;
      repeat (3) begin
         @(negedge clk);
         chk("hold done low", 32'(done), 32'd0);
         chk("hold result", 32'(result), 32'(r_hold));
      end

      for (int k = 0; k < 60; k++)
         check_op($sformatf("rnd%0d", k), 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));

      // Back-to-back: start issued in the cycle done is high is accepted.
      @(negedge clk);
      start = 1'b1; aluControl = 4'd0; operandA = 16'd3; operandB = 16'd4;
      @(negedge clk);
      chk("b2b first done", 32'(done), 32'd1);
      chk("b2b first result", 32'(result), 32'd7);
      aluControl = 4'd2; operandA = 16'd9; operandB = 16'd4;
      @(negedge clk);
      start = 1'b0;
      chk("b2b second done", 32'(done), 32'd1);
      chk("b2b second result", 32'(result), 32'd5);

      // SLL by 15 with an ignored second start at cycle 3.
      @(negedge clk);
      start = 1'b1; aluControl = 4'd7; operandA = 16'h0001; operandB = 16'h000F;
      first_done = -1; n_done = 0;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         start = (c == 3);
         if (c == 3) begin aluControl = 4'd0; operandA = 16'h1111; operandB = 16'h2222; end
         if (done) begin
            n_done++;
            if (first_done < 0) begin
               first_done = c;
               chk("sll15 result", 32'(result), 32'h8000);
            end
         end
      end
      chk("sll15 done cycle", 32'(first_done), 32'd16);
      chk("sll15 done count", 32'(n_done), 32'd1);

      // Reset during SRL by 8 aborts silently; start in the reset cycle is ignored.
      @(negedge clk);
      start = 1'b1; aluControl = 4'd6; operandA = 16'h8000; operandB = 16'h0008;
      @(negedge clk);
      start = 1'b0;
      chk("abort busy before reset", 32'(busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1; aluControl = 4'd0; operandA = 16'd1; operandB = 16'd1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort result", 32'(result), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("abort no done", 32'(n_done), 32'd0);
      check_op("post-reset add", 4'd0, 16'h0100, 16'h0023);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
